i2c_target_resp: RTL and testbench

- I2C target (slave) responder: the far end of the bus from the existing I2C controller.
- Oversamples the scl/sda lines on the system clock and detects START, repeated START and STOP.
- Matches a 7-bit address, accepts write bytes from the controller and returns read bytes to it.
- Drives sda open-drain via an output-enable; never drives scl (no clock stretching).

---
 rtl/i2c_target_resp.sv | 190 +++++++++++++++++++
 tb/tb_i2c_target_resp.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_resp.sv
// I2C target responder: oversampled scl/sda, START/STOP detection, 7-bit address match,
// write-byte receive and read-byte transmit. Define I2C_TARGET_GCALL_EN to ACK general call (8'h00).
module i2c_target_resp #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  state_t                 state, state_d;
  logic [3:0]             bit_cnt, bit_cnt_d;
  logic [7:0]             shreg, shreg_d, rx_data_d;
  logic                   sda_oe_d, rx_valid_d, tx_req_d, busy_d;
  logic [SYNC_STAGES-1:0] scl_sync_p0, sda_sync_p0;
  logic                   scl_p1, sda_p1;
  logic                   scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det, addr_match;

  // Stage p0: synchronizer chain, stage p1: edge-detect flop
  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_sync_p0 <= '1;
      sda_sync_p0 <= '1;
      scl_p1      <= 1'b1;
      sda_p1      <= 1'b1;
    end else begin
      scl_sync_p0 <= {scl_sync_p0[SYNC_STAGES-2:0], scl_i};
      sda_sync_p0 <= {sda_sync_p0[SYNC_STAGES-2:0], sda_i};
      scl_p1      <= scl_s;
      sda_p1      <= sda_s;
    end
  end

  assign scl_s     = scl_sync_p0[SYNC_STAGES-1];
  assign sda_s     = sda_sync_p0[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_p1;
  assign scl_fall  = ~scl_s & scl_p1;
  assign start_det = scl_s & scl_p1 & sda_p1 & ~sda_s;
  assign stop_det  = scl_s & scl_p1 & ~sda_p1 & sda_s;

`ifdef I2C_TARGET_GCALL_EN
  assign addr_match = (shreg[7:1] == TARGET_ADDR) || (shreg == 8'h00);
`else
  assign addr_match = (shreg[7:1] == TARGET_ADDR);
`endif

  // Stage p2: FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      bit_cnt  <= 4'd0;
      sda_oe   <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      bit_cnt  <= bit_cnt_d;
      sda_oe   <= sda_oe_d;
      rx_data  <= rx_data_d;
      rx_valid <= rx_valid_d;
      tx_req   <= tx_req_d;
      busy     <= busy_d;
    end
    shreg <= shreg_d;
  end

  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
    end else if (stop_det) begin
      state_d   = IDLE;
      bit_cnt_d = 4'd0;
    end else begin
      case (state)
        ADDR, WR_DATA, RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt_d = 4'd0;
            case (state)
              ADDR:    state_d = addr_match ? ADDR_ACK : WAIT_STOP;
              WR_DATA: state_d = WR_ACK;
              default: state_d = RD_ACK;
            endcase
          end
        end
        ADDR_ACK: if (scl_fall) state_d = shreg[0] ? RD_DATA : WR_DATA;
        WR_ACK:   if (scl_fall) state_d = WR_DATA;
        RD_ACK: begin
          // bit_cnt doubles as the "controller ACKed" flag for the ninth clock
          if (scl_rise) begin
            if (sda_s) state_d = WAIT_STOP;
            else       bit_cnt_d = 4'd1;
          end else if (scl_fall && bit_cnt != 4'd0) begin
            state_d   = RD_DATA;
            bit_cnt_d = 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sda_oe_d   = sda_oe;
    shreg_d    = shreg;
    rx_data_d  = rx_data;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    busy_d     = busy;
    if (start_det) begin
      sda_oe_d = 1'b0;
    end else if (stop_det) begin
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state)
        ADDR: begin
          if (scl_rise) begin
            shreg_d = {shreg[6:0], sda_s};
          end else if (scl_fall && bit_cnt == 4'd8) begin
            sda_oe_d = addr_match;
            busy_d   = addr_match;
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (shreg[0]) begin
              tx_req_d = 1'b1;
              shreg_d  = tx_data;
              sda_oe_d = ~tx_data[7];
            end else begin
              sda_oe_d = 1'b0;
            end
          end
        end
        WR_DATA: begin
          if (scl_rise) begin
            shreg_d = {shreg[6:0], sda_s};
            if (bit_cnt == 4'd7) begin
              rx_data_d  = {shreg[6:0], sda_s};
              rx_valid_d = 1'b1;
            end
          end else if (scl_fall && bit_cnt == 4'd8) begin
            sda_oe_d = 1'b1;
          end
        end
        WR_ACK: if (scl_fall) sda_oe_d = 1'b0;
        RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_d = 1'b0;
            end else begin
              shreg_d  = {shreg[6:0], 1'b0};
              sda_oe_d = ~shreg[6];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise && sda_s) begin
            busy_d = 1'b0;
          end else if (scl_fall && bit_cnt != 4'd0) begin
            tx_req_d = 1'b1;
            shreg_d  = tx_data;
            sda_oe_d = ~tx_data[7];
          end
        end
        default: sda_oe_d = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target_resp.sv
// Bench for i2c_target_resp: behavioural I2C controller on a wired-AND bus with an rx scoreboard.
module tb_i2c_target_resp;

  localparam int Q = 8;
`ifdef I2C_TARGET_GCALL_EN
  localparam logic GC = 1'b1;
`else
  localparam logic GC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_i;
  logic       sda_i;
  logic       sda_ctrl;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       busy;

  assign sda_i = sda_ctrl & ~sda_oe;

  i2c_target_resp dut (
    .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_req(tx_req), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       ack;
  } wvec_t;

  wvec_t      vecs[6];
  logic [7:0] exp_q[$];
  int         nchecks = 0;
  int         nerr = 0;
  int         tx_cnt = 0;
  int         rx_cnt = 0;
  logic       oe_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (rx_valid) begin
      rx_cnt++;
      if (exp_q.size() == 0) check("rx_valid_unexpected", 32'd1, 32'd0);
      else check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
    end
    if (tx_req) tx_cnt++;
    if (rx_valid && tx_req) check("rx_tx_same_clk", 32'd1, 32'd0);
    if (sda_oe) oe_seen = 1'b1;
  endtask

  task automatic wait_q();
    repeat (Q) tick();
  endtask

  task automatic bit_cycle(input logic b, output logic s);
    wait_q(); sda_ctrl = b;
    wait_q(); scl_i = 1'b1;
    wait_q(); s = sda_i;
    wait_q(); scl_i = 1'b0;
  endtask

  task automatic do_start();
    wait_q(); sda_ctrl = 1'b1;
    wait_q(); scl_i = 1'b1;
    wait_q(); sda_ctrl = 1'b0;
    wait_q(); scl_i = 1'b0;
  endtask

  task automatic do_stop();
    wait_q(); sda_ctrl = 1'b0;
    wait_q(); scl_i = 1'b1;
    wait_q(); sda_ctrl = 1'b1;
    wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 0; i < 8; i++) bit_cycle(b[7-i], s);
    bit_cycle(1'b1, ack);
  endtask

  task automatic read_byte(input logic ack_bit, input logic [7:0] next_tx, output logic [7:0] d);
    logic s;
    for (int i = 0; i < 8; i++) begin
      bit_cycle(1'b1, s);
      d[7-i] = s;
      if (i == 0) tx_data = next_tx;
    end
    bit_cycle(ack_bit, s);
  endtask

  initial begin
    logic       a;
    logic [7:0] d;
    int         rx0, tx0;

    vecs[0] = '{addr: 8'hA0, data: 8'hA5, ack: 1'b1};
    vecs[1] = '{addr: 8'hA2, data: 8'hFF, ack: 1'b0};
    vecs[2] = '{addr: 8'h00, data: 8'h11, ack: GC};
    vecs[3] = '{addr: 8'hA0, data: 8'h00, ack: 1'b1};
    vecs[4] = '{addr: 8'h20, data: 8'h3C, ack: 1'b0};
    vecs[5] = '{addr: 8'hA0, data: 8'hFF, ack: 1'b1};

    rst = 1'b0; scl_i = 1'b1; sda_ctrl = 1'b1; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_tx_req", {31'd0, tx_req}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    repeat (4) tick();

    // Table-driven write transactions
    foreach (vecs[k]) begin
      oe_seen = 1'b0;
      rx0 = rx_cnt;
      do_start();
      send_byte(vecs[k].addr, a);
      check("addr_ack", {31'd0, a}, {31'd0, ~vecs[k].ack});
      check("busy_after_addr", {31'd0, busy}, {31'd0, vecs[k].ack});
      if (vecs[k].ack) exp_q.push_back(vecs[k].data);
      send_byte(vecs[k].data, a);
      check("data_ack", {31'd0, a}, {31'd0, ~vecs[k].ack});
      do_stop();
      check("busy_after_stop", {31'd0, busy}, 32'd0);
      check("rx_pulses", rx_cnt - rx0, {31'd0, vecs[k].ack});
      check("sda_oe_seen", {31'd0, oe_seen}, {31'd0, vecs[k].ack});
      check("rx_queue_empty", exp_q.size(), 32'd0);
    end

    // Single read byte, controller NACK
    tx_data = 8'h3C;
    tx0 = tx_cnt;
    do_start();
    send_byte(8'hA1, a);
    check("rd_addr_ack", {31'd0, a}, 32'd0);
    read_byte(1'b1, 8'h3C, d);
    check("rd_byte_3c", {24'd0, d}, 32'h3C);
    check("rd_busy_after_nack", {31'd0, busy}, 32'd0);
    check("rd_sda_released", {31'd0, sda_oe}, 32'd0);
    do_stop();
    check("rd_tx_req_count", tx_cnt - tx0, 32'd1);

    // Two read bytes: ACK then NACK
    tx_data = 8'h12;
    tx0 = tx_cnt;
    do_start();
    send_byte(8'hA1, a);
    check("rd2_addr_ack", {31'd0, a}, 32'd0);
    read_byte(1'b0, 8'h34, d);
    check("rd2_byte0", {24'd0, d}, 32'h12);
    check("rd2_busy_mid", {31'd0, busy}, 32'd1);
    read_byte(1'b1, 8'h34, d);
    check("rd2_byte1", {24'd0, d}, 32'h34);
    do_stop();
    check("rd2_tx_req_count", tx_cnt - tx0, 32'd2);
    check("rd2_busy_end", {31'd0, busy}, 32'd0);

    // Write then repeated START into a read
    do_start();
    send_byte(8'hA0, a);
    check("rs_wr_addr_ack", {31'd0, a}, 32'd0);
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, a);
    check("rs_wr_data_ack", {31'd0, a}, 32'd0);
    tx_data = 8'hC3;
    do_start();
    send_byte(8'hA1, a);
    check("rs_rd_addr_ack", {31'd0, a}, 32'd0);
    check("rs_busy", {31'd0, busy}, 32'd1);
    check("rs_rx_data_held", {24'd0, rx_data}, 32'h5A);
    read_byte(1'b1, 8'hC3, d);
    check("rs_rd_byte", {24'd0, d}, 32'hC3);
    do_stop();
    check("rs_rx_queue_empty", exp_q.size(), 32'd0);

    // Reset while driving a 0 read bit
    tx_data = 8'h3C;
    do_start();
    send_byte(8'hA1, a);
    check("rst_addr_ack", {31'd0, a}, 32'd0);
    wait_q();
    check("rst_driving_zero", {31'd0, sda_oe}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_sda_released", {31'd0, sda_oe}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    sda_ctrl = 1'b1;
    wait_q(); scl_i = 1'b1;
    wait_q();
    do_start();
    send_byte(8'hA0, a);
    check("post_rst_addr_ack", {31'd0, a}, 32'd0);
    exp_q.push_back(8'h77);
    send_byte(8'h77, a);
    check("post_rst_data_ack", {31'd0, a}, 32'd0);
    do_stop();
    check("post_rst_queue_empty", exp_q.size(), 32'd0);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
